regfile_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the 32x32 register file. It shares the single register-file write port between the in-order pipeline writeback stage and the multi-cycle Booth multiplier. It tracks registers with an outstanding multiply result and tells decode when to stall. It sits between the WB stage, the multiplier and the register file's RegWrite/Write_Reg/Write_Data inputs.

---
 rtl/regfile_wb_arbiter_pkg.sv | 17 +
 rtl/regfile_scoreboard.sv | 63 ++++++
 rtl/regfile_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and grant encoding for the register-file write-port arbiter.
// No logic or state lives here. It holds only types and constants.
// Backpressure does not apply to this file.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    // Which source owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_MUL  = 2'd2
    } gnt_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-mask scoreboard for outstanding multiply results, plus the decode hazard check.
// Busy updates become visible 1 cycle after the event. The hazard output is combinational.
// There is no backpressure. The module only reports o_hazard so that decode holds.
//
// Ports: i_clk/i_rst_n clock and async active-low reset; i_set_* marks an issued multiply
// destination busy; i_clr_* clears on the multiplier write grant; i_dec_* are the decode
// sources and destination; i_rf_we/i_rf_reg are the in-flight register-file write;
// o_busy_mask is the scoreboard; o_hazard means decode must stall.
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_set_vld,
    input  logic [REG_ADDR_W-1:0] i_set_reg,
    input  logic                  i_clr_vld,
    input  logic [REG_ADDR_W-1:0] i_clr_reg,
    input  logic [REG_ADDR_W-1:0] i_dec_rd1,
    input  logic [REG_ADDR_W-1:0] i_dec_rd2,
    input  logic                  i_dec_use1,
    input  logic                  i_dec_use2,
    input  logic                  i_dec_wr,
    input  logic [REG_ADDR_W-1:0] i_dec_dest,
    input  logic                  i_rf_we,
    input  logic [REG_ADDR_W-1:0] i_rf_reg,
    output logic [NUM_REGS-1:0]   o_busy_mask,
    output logic                  o_hazard
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic                w_raw;
    logic                w_waw;
    logic                w_pending_wr;

    // Register 0 is hardwired, so it is never marked busy.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_vld && (i_set_reg != '0)) w_set_mask[i_set_reg] = 1'b1;
        if (i_clr_vld)                      w_clr_mask[i_clr_reg] = 1'b1;
    end

    // Set is applied after clear, so a new issue to the same register wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_busy <= '0;
        else          r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
    end

    assign w_raw = (i_dec_use1 && r_busy[i_dec_rd1]) || (i_dec_use2 && r_busy[i_dec_rd2]);
    assign w_waw = i_dec_wr && (i_dec_dest != '0) && r_busy[i_dec_dest];

    // The register-file write registered last edge lands at the end of this cycle.
    // A source that reads it now would see the stale value.
    assign w_pending_wr = i_rf_we && (i_rf_reg != '0) &&
                          ((i_dec_use1 && (i_dec_rd1 == i_rf_reg)) ||
                           (i_dec_use2 && (i_dec_rd2 == i_rf_reg)));

    assign o_busy_mask = r_busy;
    assign o_hazard    = i_rst_n && (w_raw || w_waw || w_pending_wr);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between WB (always wins) and the multiplier.
// The grant (o_mul_ack) is combinational. The register-file write is registered 1 cycle after the grant.
// WB cannot be stalled. A waiting multiplier raises o_wb_hold after MAX_WAIT cycles to get a bubble.
//
// Ports: i_wb_* writeback request; i_mul_issue* multiply issued; i_mul_req/reg/data held
// until o_mul_ack; i_dec_* decode operands; o_hazard_stall decode hold; o_wb_hold WB bubble
// demand; o_rf_we/reg/data register-file write port; o_busy_mask outstanding multiplies.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wb_we,
    input  logic [REG_ADDR_W-1:0] i_wb_reg,
    input  logic [DATA_W-1:0]     i_wb_data,
    input  logic                  i_mul_issue,
    input  logic [REG_ADDR_W-1:0] i_mul_issue_reg,
    input  logic                  i_mul_req,
    input  logic [REG_ADDR_W-1:0] i_mul_reg,
    input  logic [DATA_W-1:0]     i_mul_data,
    output logic                  o_mul_ack,
    input  logic [REG_ADDR_W-1:0] i_dec_rd1,
    input  logic [REG_ADDR_W-1:0] i_dec_rd2,
    input  logic                  i_dec_use1,
    input  logic                  i_dec_use2,
    input  logic                  i_dec_wr,
    input  logic [REG_ADDR_W-1:0] i_dec_dest,
    output logic                  o_hazard_stall,
    output logic                  o_wb_hold,
    output logic                  o_rf_we,
    output logic [REG_ADDR_W-1:0] o_rf_reg,
    output logic [DATA_W-1:0]     o_rf_data,
    output logic [NUM_REGS-1:0]   o_busy_mask
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    gnt_e                  w_gnt;
    logic                  w_mul_ack;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic [CNT_W-1:0]      w_wait_cnt_nxt;
    logic                  r_wb_hold;
    logic                  r_rf_we;
    logic [REG_ADDR_W-1:0] r_rf_reg;
    logic [DATA_W-1:0]     r_rf_data;

    // A WB write to r0 is not a request, so the multiplier may take that cycle.
    always_comb begin
        w_gnt = GNT_NONE;
        if (!i_rst_n)                             w_gnt = GNT_NONE;
        else if (i_wb_we && (i_wb_reg != '0))     w_gnt = GNT_WB;
        else if (i_mul_req)                       w_gnt = GNT_MUL;
    end

    assign w_mul_ack = (w_gnt == GNT_MUL);

    // An ack to r0 retires the request without a register-file write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rf_we   <= 1'b0;
            r_rf_reg  <= '0;
            r_rf_data <= '0;
        end else begin
            case (w_gnt)
                GNT_WB: begin
                    r_rf_we   <= 1'b1;
                    r_rf_reg  <= i_wb_reg;
                    r_rf_data <= i_wb_data;
                end
                GNT_MUL: begin
                    r_rf_we <= (i_mul_reg != '0);
                    if (i_mul_reg != '0) begin
                        r_rf_reg  <= i_mul_reg;
                        r_rf_data <= i_mul_data;
                    end
                end
                default: r_rf_we <= 1'b0;
            endcase
        end
    end

    always_comb begin
        w_wait_cnt_nxt = '0;
        if (i_mul_req && !w_mul_ack)
            w_wait_cnt_nxt = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;
    end

    // The hold stays up until the multiplier is served, even if WB ignores it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
            r_wb_hold  <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_mul_ack)                      r_wb_hold <= 1'b0;
            else if (w_wait_cnt_nxt == CNT_MAX) r_wb_hold <= 1'b1;
        end
    end

    regfile_scoreboard u_scoreboard (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_set_vld   (i_mul_issue),
        .i_set_reg   (i_mul_issue_reg),
        .i_clr_vld   (w_mul_ack),
        .i_clr_reg   (i_mul_reg),
        .i_dec_rd1   (i_dec_rd1),
        .i_dec_rd2   (i_dec_rd2),
        .i_dec_use1  (i_dec_use1),
        .i_dec_use2  (i_dec_use2),
        .i_dec_wr    (i_dec_wr),
        .i_dec_dest  (i_dec_dest),
        .i_rf_we     (r_rf_we),
        .i_rf_reg    (r_rf_reg),
        .o_busy_mask (o_busy_mask),
        .o_hazard    (o_hazard_stall)
    );

    assign o_mul_ack = w_mul_ack;
    assign o_wb_hold = r_wb_hold;
    assign o_rf_we   = r_rf_we;
    assign o_rf_reg  = r_rf_reg;
    assign o_rf_data = r_rf_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: a behavioural model is compared with the DUT every cycle,
// and directed scenarios add literal checks at fixed points.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled on the falling edge.
module tb_regfile_wb_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [31:0] wb_data = '0;
    logic        mul_issue = 1'b0;
    logic [4:0]  mul_issue_reg = '0;
    logic        mul_req = 1'b0;
    logic [4:0]  mul_reg = '0;
    logic [31:0] mul_data = '0;
    logic [4:0]  dec_rd1 = '0, dec_rd2 = '0, dec_dest = '0;
    logic        dec_use1 = 1'b0, dec_use2 = 1'b0, dec_wr = 1'b0;
    logic        mul_ack, hazard_stall, wb_hold, rf_we;
    logic [4:0]  rf_reg;
    logic [31:0] rf_data, busy_mask;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_we(wb_we), .i_wb_reg(wb_reg), .i_wb_data(wb_data),
        .i_mul_issue(mul_issue), .i_mul_issue_reg(mul_issue_reg),
        .i_mul_req(mul_req), .i_mul_reg(mul_reg), .i_mul_data(mul_data),
        .o_mul_ack(mul_ack),
        .i_dec_rd1(dec_rd1), .i_dec_rd2(dec_rd2),
        .i_dec_use1(dec_use1), .i_dec_use2(dec_use2),
        .i_dec_wr(dec_wr), .i_dec_dest(dec_dest),
        .o_hazard_stall(hazard_stall), .o_wb_hold(wb_hold),
        .o_rf_we(rf_we), .o_rf_reg(rf_reg), .o_rf_data(rf_data),
        .o_busy_mask(busy_mask)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy [32];
    bit          m_rf_we   = 1'b0;
    logic [4:0]  m_rf_reg  = '0;
    logic [31:0] m_rf_data = '0;
    int          m_waited  = 0;   // consecutive cycles the current request went unserved
    bit          m_hold    = 1'b0;

    function automatic bit exp_ack();
        return rst_n && mul_req && !(wb_we && wb_reg != 0);
    endfunction

    function automatic bit exp_stall();
        bit s = 1'b0;
        if (!rst_n) return 1'b0;
        if (dec_use1 && m_busy[dec_rd1]) s = 1'b1;
        if (dec_use2 && m_busy[dec_rd2]) s = 1'b1;
        if (dec_wr && dec_dest != 0 && m_busy[dec_dest]) s = 1'b1;
        if (m_rf_we && m_rf_reg != 0 &&
            ((dec_use1 && dec_rd1 == m_rf_reg) || (dec_use2 && dec_rd2 == m_rf_reg))) s = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] exp_mask();
        logic [31:0] m = '0;
        for (int i = 0; i < 32; i++) m[i] = m_busy[i];
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_rf_we = 1'b0; m_rf_reg = '0; m_rf_data = '0;
            m_waited = 0; m_hold = 1'b0;
        end else begin
            bit ack;
            ack = exp_ack();
            if (wb_we && wb_reg != 0) begin
                m_rf_we = 1'b1; m_rf_reg = wb_reg; m_rf_data = wb_data;
            end else if (ack && mul_reg != 0) begin
                m_rf_we = 1'b1; m_rf_reg = mul_reg; m_rf_data = mul_data;
            end else begin
                m_rf_we = 1'b0;
            end
            if (ack) m_busy[mul_reg] = 1'b0;
            if (mul_issue && mul_issue_reg != 0) m_busy[mul_issue_reg] = 1'b1;
            m_waited = (mul_req && !ack) ? m_waited + 1 : 0;
            if (ack) m_hold = 1'b0;
            else if (m_waited >= MAX_WAIT) m_hold = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            chk("mdl_mul_ack", {31'b0, mul_ack}, {31'b0, exp_ack()});
            chk("mdl_hazard",  {31'b0, hazard_stall}, {31'b0, exp_stall()});
            chk("mdl_wb_hold", {31'b0, wb_hold}, {31'b0, m_hold});
            chk("mdl_rf_we",   {31'b0, rf_we}, {31'b0, m_rf_we});
            chk("mdl_rf_reg",  {27'b0, rf_reg}, {27'b0, m_rf_reg});
            chk("mdl_rf_data", rf_data, m_rf_data);
            chk("mdl_busy",    busy_mask, exp_mask());
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int k;
        bit seen;
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        // Reset state, then idle
        @(negedge clk);
        chk("idle_ack", {31'b0, mul_ack}, 32'd0);
        chk("idle_busy", busy_mask, 32'd0);
        chk("idle_rf_we", {31'b0, rf_we}, 32'd0);
        chk("idle_hold", {31'b0, wb_hold}, 32'd0);
        next_cycle();

        // WB beats the multiplier, and the multiplier is served next
        wb_we = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEADBEEF;
        mul_req = 1'b1; mul_reg = 5'd7; mul_data = 32'h12345678;
        @(negedge clk);
        chk("wb_wins_ack", {31'b0, mul_ack}, 32'd0);
        next_cycle();
        wb_we = 1'b0;
        @(negedge clk);
        chk("wb_rf_we", {31'b0, rf_we}, 32'd1);
        chk("wb_rf_reg", {27'b0, rf_reg}, 32'd5);
        chk("wb_rf_data", rf_data, 32'hDEADBEEF);
        chk("mul_ack_free", {31'b0, mul_ack}, 32'd1);
        next_cycle();
        mul_req = 1'b0;
        @(negedge clk);
        chk("mul_rf_reg", {27'b0, rf_reg}, 32'd7);
        chk("mul_rf_data", rf_data, 32'h12345678);
        next_cycle();

        // Scoreboard RAW stall on r9
        mul_issue = 1'b1; mul_issue_reg = 5'd9;
        next_cycle();
        mul_issue = 1'b0; dec_use1 = 1'b1; dec_rd1 = 5'd9;
        @(negedge clk);
        chk("busy9", busy_mask, 32'h200);
        chk("raw_stall", {31'b0, hazard_stall}, 32'd1);
        next_cycle();
        next_cycle();
        mul_req = 1'b1; mul_reg = 5'd9; mul_data = 32'h0000AAAA;
        @(negedge clk);
        chk("ack9", {31'b0, mul_ack}, 32'd1);
        chk("stall_at_ack", {31'b0, hazard_stall}, 32'd1);
        next_cycle();
        mul_req = 1'b0;
        @(negedge clk);
        chk("busy9_clr", busy_mask, 32'd0);
        chk("stall_wr_pending", {31'b0, hazard_stall}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("stall_released", {31'b0, hazard_stall}, 32'd0);
        next_cycle();
        dec_use1 = 1'b0;

        // Same-cycle set and clear of r9: the set wins
        mul_issue = 1'b1; mul_issue_reg = 5'd9;
        next_cycle();
        mul_req = 1'b1; mul_reg = 5'd9; mul_data = 32'h1;
        next_cycle();
        mul_issue = 1'b0; mul_req = 1'b0;
        @(negedge clk);
        chk("set_wins", busy_mask, 32'h200);
        mul_req = 1'b1;
        next_cycle();
        mul_req = 1'b0;
        @(negedge clk);
        chk("busy9_final_clr", busy_mask, 32'd0);
        next_cycle();

        // Starvation: continuous WB traffic against a waiting multiply
        wb_we = 1'b1; wb_reg = 5'd3; wb_data = 32'h33;
        mul_req = 1'b1; mul_reg = 5'd4; mul_data = 32'h44;
        seen = 1'b0; k = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            if (wb_hold) seen = 1'b1;
            else begin
                k++;
                next_cycle();
            end
        end
        if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL starve_timeout: wb_hold never rose within 20 cycles");
        end else begin
            chk("hold_rise_cycle", k, 32'd4);
        end
        next_cycle();
        wb_we = 1'b0;
        @(negedge clk);
        chk("starve_ack", {31'b0, mul_ack}, 32'd1);
        chk("hold_at_ack", {31'b0, wb_hold}, 32'd1);
        next_cycle();
        mul_req = 1'b0;
        @(negedge clk);
        chk("hold_fall", {31'b0, wb_hold}, 32'd0);
        chk("starve_rf_reg", {27'b0, rf_reg}, 32'd4);
        next_cycle();

        // Zero destinations: granted with no register-file write
        wb_we = 1'b1; wb_reg = 5'd0; wb_data = 32'h55;
        mul_req = 1'b1; mul_reg = 5'd0; mul_data = 32'h66;
        @(negedge clk);
        chk("r0_mul_ack", {31'b0, mul_ack}, 32'd1);
        next_cycle();
        wb_we = 1'b0; mul_req = 1'b0;
        @(negedge clk);
        chk("r0_rf_we", {31'b0, rf_we}, 32'd0);
        next_cycle();

        // Asynchronous reset in the middle of a starved wait
        mul_issue = 1'b1; mul_issue_reg = 5'd12;
        next_cycle();
        mul_issue = 1'b0;
        wb_we = 1'b1; wb_reg = 5'd3; wb_data = 32'h77;
        mul_req = 1'b1; mul_reg = 5'd4;
        for (int i = 0; i < 5; i++) next_cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_mask, 32'd0);
        chk("arst_rf_we", {31'b0, rf_we}, 32'd0);
        chk("arst_rf_reg", {27'b0, rf_reg}, 32'd0);
        chk("arst_rf_data", rf_data, 32'd0);
        chk("arst_hold", {31'b0, wb_hold}, 32'd0);
        chk("arst_ack", {31'b0, mul_ack}, 32'd0);
        wb_we = 1'b0; mul_req = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        next_cycle();
        chk_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
